// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Command initiator for the 8-bit combinational ALU. Commands (a, b, opcode)
// are buffered in a small FIFO and issued one at a time onto the ALU inputs.
// After a programmable settle time, the ALU result and flags are captured,
// sanitized per opcode, and returned on a valid/ready response channel.
// Compare commands get one extra cycle with alu_control=7 first. That cycle
// clears the ALU's sticky flags so the compare result is not polluted.
//
// Ports:
//   clk, rst                  rising-edge clock, async active-high reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = !full)
//   cmd_a, cmd_b, cmd_op      command operands and opcode
//   alu_a, alu_b, alu_control registered drive into the ALU
//   alu_c, alu_borrow, alu_carry, alu_equal, alu_less, alu_more
//                             ALU result and flags
//   rsp_valid/rsp_ready       response handshake
//   rsp_c, rsp_flags, rsp_op, rsp_err
//                             captured response; flags = {borrow,carry,equal,less,more}
//   done_cnt                  completed responses, wraps at 256
module alu_cmd_issuer #(
   parameter int DEPTH         = 4,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic [2:0] cmd_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_control,
   input  logic [7:0] alu_c,
   input  logic       alu_borrow,
   input  logic       alu_carry,
   input  logic       alu_equal,
   input  logic       alu_less,
   input  logic       alu_more,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_c,
   output logic [4:0] rsp_flags,
   output logic [2:0] rsp_op,
   output logic       rsp_err,
   output logic [7:0] done_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, CLR, SETTLE, HOLD} state_t;

   logic [18:0]   fifo_mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [7:0]    head_a;
   logic [7:0]    head_b;
   logic [2:0]    head_op;
   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] settle_cnt;
   logic          settle_done;
   logic [2:0]    op_q;
   logic          capture;
   logic          handshake;
   logic [7:0]    cap_c;
   logic [4:0]    cap_flags;
   logic          cap_err;

   // Pointers carry one extra wrap bit: equal pointers mean empty, and
   // pointers differing only in the wrap bit mean full.
   assign empty       = (wr_ptr == rd_ptr);
   assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign cmd_ready   = !full && !rst;
   assign push        = cmd_valid && cmd_ready;
   assign {head_a, head_b, head_op} = fifo_mem[rd_ptr[AW-1:0]];
   assign settle_done = (settle_cnt == CW'(SETTLE_CYCLES - 1));

   // FIFO storage; contents need no reset because the pointers gate reads.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= {cmd_a, cmd_b, cmd_op};
      end
   end

   // FIFO pointers advance on push/pop and wrap naturally through the extra bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic. A pop always starts a new command, either from IDLE
   // or straight out of HOLD on the handshake edge. A compare goes through
   // CLR first; all other ops go directly to SETTLE.
   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      capture   = 1'b0;
      handshake = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = (head_op == 3'd6) ? CLR : SETTLE;
            end
         end
         CLR: begin
            state_d = SETTLE;
         end
         SETTLE: begin
            if (settle_done) begin
               capture = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (rsp_ready) begin
               handshake = 1'b1;
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = (head_op == 3'd6) ? CLR : SETTLE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Keep only the flags meaningful for the issued op. Compare and the
   // invalid op return a zero result no matter what the ALU drives.
   always_comb begin
      cap_c     = alu_c;
      cap_flags = 5'b0;
      cap_err   = 1'b0;
      case (op_q)
         3'd0: cap_flags = {1'b0, alu_carry, 3'b000};
         3'd1: cap_flags = {alu_borrow, 4'b0000};
         3'd6: begin
            cap_c     = 8'd0;
            cap_flags = {2'b00, alu_equal, alu_less, alu_more};
         end
         3'd7: begin
            cap_c   = 8'd0;
            cap_err = 1'b1;
         end
         default: cap_flags = 5'b0;
      endcase
   end

   // Datapath. The ALU drive registers load on pop and switch from 7 to 6
   // after the CLR cycle. The response registers load on capture and hold
   // until the handshake. rsp_valid drops on every handshake, so during a
   // back-to-back command it stays low until the new capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a       <= '0;
         alu_b       <= '0;
         alu_control <= '0;
         op_q        <= '0;
         settle_cnt  <= '0;
         rsp_valid   <= 1'b0;
         rsp_c       <= '0;
         rsp_flags   <= '0;
         rsp_op      <= '0;
         rsp_err     <= 1'b0;
         done_cnt    <= '0;
      end else begin
         if (handshake) begin
            done_cnt  <= done_cnt + 8'd1;
            rsp_valid <= 1'b0;
         end
         if (pop) begin
            alu_a       <= head_a;
            alu_b       <= head_b;
            alu_control <= (head_op == 3'd6) ? 3'd7 : head_op;
            op_q        <= head_op;
            settle_cnt  <= '0;
         end else if (state_q == CLR) begin
            alu_control <= 3'd6;
            settle_cnt  <= '0;
         end else if (state_q == SETTLE && !settle_done) begin
            settle_cnt <= settle_cnt + 1'b1;
         end
         if (capture) begin
            rsp_valid <= 1'b1;
            rsp_c     <= cap_c;
            rsp_flags <= cap_flags;
            rsp_op    <= op_q;
            rsp_err   <= cap_err;
         end
      end
   end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator for the 8-bit combinational ALU. Buffers operation commands (A, B, opcode) in a small FIFO and drives one command at a time onto the ALU operand/control inputs.
- Waits a programmable settle time, then captures the ALU result and flags and returns them on a valid/ready response channel.
- Sits between a command source (testbench or controller) and the ALU instance.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, minimum 2).
- SETTLE_CYCLES, 1, clock edges the ALU inputs are held before result capture (minimum 1).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept; equals !full.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- cmd_op  input  3  opcode: 0 add, 1 sub, 2 xor, 3 and, 4 nor, 5 nand, 6 compare, 7 invalid/clear.
- alu_a  output  8  to ALU a.
- alu_b  output  8  to ALU b.
- alu_control  output  3  to ALU alu_control.
- alu_c  input  8  from ALU c.
- alu_borrow, alu_carry, alu_equal, alu_less, alu_more  input  1 each  ALU flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_c  output  8  captured result.
- rsp_flags  output  5  {borrow, carry, equal, less, more}, sanitized.
- rsp_op  output  3  opcode of this response.
- rsp_err  output  1  command opcode was 7.
- done_cnt  output  8  completed responses, wraps 255->0.

Behaviour:
- Reset (async, any time): FIFO emptied, state IDLE, all outputs 0 (cmd_ready becomes 1 once rst is released). Any in-flight command is discarded with no response.
- Push: on a clk edge with cmd_valid && cmd_ready. A push and a pop may occur on the same edge.
- FSM states: IDLE, CLR, SETTLE, HOLD.
- IDLE:
  - FIFO non-empty -> pop, register cmd_a/cmd_b into alu_a/alu_b.
  - Popped op == 6 -> drive alu_control=7 and go to CLR.
  - Otherwise -> drive alu_control=op and go to SETTLE.
  - alu_* outputs hold their last values while idle.
- CLR: exactly one cycle with alu_control=7, which clears the ALU's sticky compare/carry/borrow flags. Then drive alu_control=6 and go to SETTLE.
- SETTLE:
  - Counts SETTLE_CYCLES edges. On the final edge, capture rsp_c, rsp_flags, rsp_op and rsp_err, set rsp_valid=1, go to HOLD.
- Sanitizing at capture:
  - op 0: only carry passed; other flags 0.
  - op 1: only borrow passed.
  - ops 2-5: all flags 0.
  - op 6: equal/less/more passed, borrow/carry 0, rsp_c forced 0.
  - op 7: rsp_c=0, flags=0, rsp_err=1.
- HOLD:
  - rsp_* stable while rsp_valid && !rsp_ready.
  - On handshake: done_cnt+1 (mod 256). If FIFO is non-empty, pop on the same edge and go to CLR or SETTLE as in IDLE (back-to-back). Otherwise clear rsp_valid and go to IDLE.
  - In the back-to-back case, rsp_valid drops for the new command's CLR/SETTLE interval.
- Latency: command pushed at edge E with FSM in IDLE and FIFO empty -> rsp_valid high after edge E+1+SETTLE_CYCLES (+1 for op 6). Default: 2 edges (3 for compare).
- Capacity: with rsp_ready held 0, DEPTH+1 commands are accepted (one in HOLD, DEPTH in FIFO) before cmd_ready=0.
- FIFO pointers are one bit wider than the index (log2(DEPTH)+1 bits). full/empty come from pointer compare; pointers wrap naturally.

Test Plan:
- Add: a=200, b=100, op=0 -> after 2 edges rsp_c=44, rsp_flags=5'b01000, rsp_err=0; handshake -> done_cnt=1.
- Sub, then compare: first a=5, b=10, op=1 -> rsp_c=251, flags=5'b10000. Then a=7, b=7, op=6 -> alu_control shows 7 then 6, rsp_c=0, flags=5'b00100, latency 3.
- Stale-flag check: compare 9 vs 3 (flags=00001), then compare 3 vs 3 -> flags=00100 with more=0, proving CLR ran.
- Backpressure: rsp_ready=0, push 6 ops on consecutive cycles -> exactly 5 accepted, cmd_ready=0. Release rsp_ready -> 5 responses in push order, no loss or duplication; done_cnt=5.
- Invalid: op=7, a=0xFF, b=0x01 -> rsp_c=0, flags=0, rsp_err=1, rsp_op=7.
- Reset mid-operation: assert rst during SETTLE with 2 commands queued -> rsp_valid, alu_* and done_cnt go 0 immediately. After release, no response appears and cmd_ready=1.
